simd_issue_scheduler: RTL

//  Per-lane instruction issue stage sitting directly upstream of the SIMD lane.

---
 rtl/simd_issue_scheduler_pkg.sv | 29 ++
 rtl/simd_issue_scheduler_arbiter.sv | 38 +++
 rtl/simd_issue_scheduler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/simd_issue_scheduler_pkg.sv
// Shared types and sizing for the SIMD per-lane issue scheduler.
// One decoded instruction is buffered per thread; the struct is the slot payload.
package simd_issue_scheduler_pkg;

    localparam int NUM_THREADS = 16;
    localparam int NUM_REGS    = 32;
    localparam int DATA_W      = 32;
    localparam int TID_W       = $clog2(NUM_THREADS);
    localparam int REG_W       = $clog2(NUM_REGS);

    typedef struct packed {
        logic [4:0]        funct4;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  ad1;
        logic [REG_W-1:0]  ad2;
        logic [REG_W-1:0]  ad3;
        logic              use_imm;
        logic              is_int;
        logic              is_float;
        logic              we3;
    } issue_instr_t;

    // Register 0 is hardwired zero, so its scoreboard bit always reads clear.
    function automatic logic reg_busy(input logic [NUM_REGS-1:0] row,
                                      input logic [REG_W-1:0]    ad);
        return (ad != '0) && row[ad];
    endfunction

endpackage

// File: rtl/simd_issue_scheduler_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 16,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any_grant
);

    localparam int SW = IDX_W + 1;

    logic [SW-1:0]    sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + SW'(i);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/simd_issue_scheduler.sv
// Per-lane issue stage: one buffered instruction per thread, per-thread register
// scoreboard, round-robin selection of a hazard-free thread into the issue register.
module simd_issue_scheduler
    import simd_issue_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TID_W-1:0]  in_tid,
    input  logic [4:0]        in_funct4,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_W-1:0]  in_ad1,
    input  logic [REG_W-1:0]  in_ad2,
    input  logic [REG_W-1:0]  in_ad3,
    input  logic              in_use_imm,
    input  logic              in_is_int,
    input  logic              in_is_float,
    input  logic              in_we3,
    input  logic              lane_stall,
    output logic              iss_valid,
    output logic [TID_W-1:0]  iss_tid,
    output logic [4:0]        iss_funct4,
    output logic [DATA_W-1:0] iss_imm,
    output logic [REG_W-1:0]  iss_ad1,
    output logic [REG_W-1:0]  iss_ad2,
    output logic [REG_W-1:0]  iss_ad3,
    output logic              iss_use_imm,
    output logic              iss_is_int,
    output logic              iss_is_float,
    output logic              iss_we3,
    input  logic              wb_we,
    input  logic [REG_W-1:0]  wb_ad3,
    input  logic [TID_W-1:0]  wb_tid,
    output logic              idle
);

    issue_instr_t           slot_q [NUM_THREADS];
    logic [NUM_THREADS-1:0] slot_valid;
    logic [NUM_REGS-1:0]    sb [NUM_THREADS];
    logic [TID_W-1:0]       rr_ptr;

    issue_instr_t           iss_q;
    logic [TID_W-1:0]       iss_tid_q;
    logic                   iss_valid_q;

    issue_instr_t           in_instr;
    logic                   accept;
    logic [NUM_THREADS-1:0] accept_mask;
    logic [NUM_THREADS-1:0] eligible;
    logic [NUM_THREADS-1:0] req;
    logic [NUM_THREADS-1:0] grant;
    logic [TID_W-1:0]       grant_idx;
    logic                   any_grant;
    issue_instr_t           sel_instr;
    logic [TID_W-1:0]       next_ptr;
    logic [NUM_REGS-1:0]    set_mask;
    logic [NUM_REGS-1:0]    clr_mask;
    logic                   sb_any;

    // A slot that is issuing this cycle is still valid, so it cannot be refilled yet.
    assign in_ready = !slot_valid[in_tid];
    assign accept   = in_valid && in_ready;

    always_comb begin
        in_instr.funct4   = in_funct4;
        in_instr.imm      = in_imm;
        in_instr.ad1      = in_ad1;
        in_instr.ad2      = in_ad2;
        in_instr.ad3      = in_ad3;
        in_instr.use_imm  = in_use_imm;
        in_instr.is_int   = in_is_int;
        in_instr.is_float = in_is_float;
        in_instr.we3      = in_we3;
        accept_mask       = '0;
        if (accept) begin
            accept_mask[in_tid] = 1'b1;
        end
    end

    always_comb begin
        eligible = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            eligible[t] = slot_valid[t]
                && !reg_busy(sb[t], slot_q[t].ad1)
                && (slot_q[t].use_imm || !reg_busy(sb[t], slot_q[t].ad2))
                && (!slot_q[t].we3 || !reg_busy(sb[t], slot_q[t].ad3));
        end
    end

    // Gating the requests with the stall keeps grant, slot clears and sb sets quiet.
    assign req = lane_stall ? '0 : eligible;

    rr_arbiter #(
        .N     (NUM_THREADS),
        .IDX_W (TID_W)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign sel_instr = slot_q[grant_idx];
    assign next_ptr  = (grant_idx == TID_W'(NUM_THREADS - 1)) ? '0 : grant_idx + 1'b1;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (any_grant && sel_instr.we3 && (sel_instr.ad3 != '0)) begin
            set_mask[sel_instr.ad3] = 1'b1;
        end
        if (wb_we && (wb_ad3 != '0)) begin
            clr_mask[wb_ad3] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid <= '0;
        end else begin
            slot_valid <= (slot_valid & ~grant) | accept_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            slot_q[in_tid] <= in_instr;
        end
    end

    // Set is ORed in after the clear so a coincident set on the same bit wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                sb[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                sb[t] <= (sb[t] & ~((wb_tid == TID_W'(t)) ? clr_mask : '0))
                       | ((grant_idx == TID_W'(t)) ? set_mask : '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_q <= 1'b0;
            iss_q       <= '0;
            iss_tid_q   <= '0;
            rr_ptr      <= '0;
        end else if (!lane_stall) begin
            iss_valid_q <= any_grant;
            if (any_grant) begin
                iss_q     <= sel_instr;
                iss_tid_q <= grant_idx;
                rr_ptr    <= next_ptr;
            end
        end
    end

    always_comb begin
        sb_any = 1'b0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            sb_any = sb_any | (|sb[t]);
        end
    end

    assign idle = !(|slot_valid) && !iss_valid_q && !sb_any;

    assign iss_valid    = iss_valid_q;
    assign iss_tid      = iss_tid_q;
    assign iss_funct4   = iss_q.funct4;
    assign iss_imm      = iss_q.imm;
    assign iss_ad1      = iss_q.ad1;
    assign iss_ad2      = iss_q.ad2;
    assign iss_ad3      = iss_q.ad3;
    assign iss_use_imm  = iss_q.use_imm;
    assign iss_is_int   = iss_q.is_int;
    assign iss_is_float = iss_q.is_float;
    assign iss_we3      = iss_q.we3;

endmodule
